// File: rtl/ps2_lane_decoder_if.sv
// ps2_lane_decoder_if: byte-input / event-output bundle for ps2_lane_decoder.
//   master : drives rx_done_tick, rx_data, evt_ready and observes the event head
//   slave  : the decoder, which consumes bytes and presents events
interface ps2_lane_decoder_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          rx_done_tick;
    logic [7:0]    rx_data;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_lane;
    logic          evt_press;
    logic [3:0]    held;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    modport master (
        output rx_done_tick, rx_data, evt_ready,
        input  evt_valid, evt_lane, evt_press, held, overflow, fifo_count
    );

    modport slave (
        input  rx_done_tick, rx_data, evt_ready,
        output evt_valid, evt_lane, evt_press, held, overflow, fifo_count
    );
endinterface

// File: rtl/ps2_lane_decoder.sv
// ps2_lane_decoder: turns a PS/2 set-2 byte stream into per-lane press/release
// events for four note lanes, with break/extended prefix parsing, typematic
// repeat suppression and a small event FIFO with valid/ready handshake.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - slave side: rx_done_tick/rx_data in, evt_ready in,
//           evt_valid/evt_lane/evt_press/held/overflow/fifo_count out
module ps2_lane_decoder #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [7:0]  KEY0           = 8'h1C,
    parameter logic [7:0]  KEY1           = 8'h1B,
    parameter logic [7:0]  KEY2           = 8'h23,
    parameter logic [7:0]  KEY3           = 8'h2B,
    parameter int unsigned PREFIX_TIMEOUT = 200000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_lane_decoder_if.slave  bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [7:0]  BYTE_BRK = 8'hF0;
    localparam logic [7:0]  BYTE_EXT = 8'hE0;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t        state;
    logic [TW-1:0] toCnt;
    logic [3:0]    heldQ;
    logic          overflowQ;
    logic          evtValidQ;
    logic [1:0]    evtLaneQ;
    logic          evtPressQ;
    logic [CW-1:0] countQ;
    logic [PW-1:0] rdPtrQ;
    logic [PW-1:0] wrPtrQ;
    logic [1:0]    memLane  [FIFO_DEPTH];
    logic          memPress [FIFO_DEPTH];

    logic          laneHit;
    logic [1:0]    laneIdx;
    logic          evtGen;
    logic          evtPress;
    logic [3:0]    heldNext;
    logic          full;
    logic          pop;
    logic          push;
    logic          dropEvt;
    logic [CW-1:0] countNext;
    logic [PW-1:0] rdPtrNext;
    logic [1:0]    headLane;
    logic          headPress;

    assign bus.held       = heldQ;
    assign bus.overflow   = overflowQ;
    assign bus.evt_valid  = evtValidQ;
    assign bus.evt_lane   = evtLaneQ;
    assign bus.evt_press  = evtPressQ;
    assign bus.fifo_count = countQ;

    // Lane lookup of the received byte; lower lane index wins on duplicate keys.
    always_comb begin
        laneHit = 1'b1;
        laneIdx = 2'd0;
        if (bus.rx_data == KEY0)      laneIdx = 2'd0;
        else if (bus.rx_data == KEY1) laneIdx = 2'd1;
        else if (bus.rx_data == KEY2) laneIdx = 2'd2;
        else if (bus.rx_data == KEY3) laneIdx = 2'd3;
        else                          laneHit = 1'b0;
    end

    // Event generation: only edges of the held state produce events, which
    // filters typematic repeats and releases of keys that were never pressed.
    always_comb begin
        evtGen   = 1'b0;
        evtPress = 1'b0;
        heldNext = heldQ;
        if (bus.rx_done_tick && laneHit) begin
            if (state == IDLE && !heldQ[laneIdx]) begin
                evtGen            = 1'b1;
                evtPress          = 1'b1;
                heldNext[laneIdx] = 1'b1;
            end else if (state == BRK && heldQ[laneIdx]) begin
                evtGen            = 1'b1;
                heldNext[laneIdx] = 1'b0;
            end
        end
    end

    // FIFO bookkeeping; a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        full      = (countQ == CW'(FIFO_DEPTH));
        pop       = evtValidQ && bus.evt_ready;
        push      = evtGen && (!full || pop);
        dropEvt   = evtGen && full && !pop;
        countNext = countQ + CW'(push) - CW'(pop);
        rdPtrNext = pop ? rdPtrQ + PW'(1) : rdPtrQ;
        // The new head is the entry being written when it lands at the read pointer.
        if (push && (wrPtrQ == rdPtrNext)) begin
            headLane  = laneIdx;
            headPress = evtPress;
        end else begin
            headLane  = memLane[rdPtrNext];
            headPress = memPress[rdPtrNext];
        end
    end

    // Parser FSM, timeout counter, held state and FIFO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            toCnt     <= '0;
            heldQ     <= '0;
            overflowQ <= 1'b0;
            evtValidQ <= 1'b0;
            evtLaneQ  <= 2'd0;
            evtPressQ <= 1'b0;
            countQ    <= '0;
            rdPtrQ    <= '0;
            wrPtrQ    <= '0;
        end else begin
            if (bus.rx_done_tick) begin
                toCnt <= '0;
                case (state)
                    IDLE: begin
                        if (bus.rx_data == BYTE_BRK)      state <= BRK;
                        else if (bus.rx_data == BYTE_EXT) state <= EXT;
                        else                              state <= IDLE;
                    end
                    BRK, EXT: begin
                        if (bus.rx_data == BYTE_BRK)      state <= (state == BRK) ? BRK : EXT_BRK;
                        else if (bus.rx_data == BYTE_EXT) state <= EXT;
                        else                              state <= IDLE;
                    end
                    EXT_BRK: begin
                        // A fresh E0 restarts an extended sequence.
                        if (bus.rx_data == BYTE_BRK)      state <= EXT_BRK;
                        else if (bus.rx_data == BYTE_EXT) state <= EXT;
                        else                              state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                toCnt <= '0;
            end else if (toCnt == TW'(PREFIX_TIMEOUT - 1)) begin
                state <= IDLE;
                toCnt <= '0;
            end else begin
                toCnt <= toCnt + TW'(1);
            end

            heldQ <= heldNext;
            if (dropEvt) overflowQ <= 1'b1;

            if (push) begin
                memLane[wrPtrQ]  <= laneIdx;
                memPress[wrPtrQ] <= evtPress;
                wrPtrQ           <= wrPtrQ + PW'(1);
            end
            rdPtrQ    <= rdPtrNext;
            countQ    <= countNext;
            evtValidQ <= (countNext != '0);
            if (countNext != '0) begin
                evtLaneQ  <= headLane;
                evtPressQ <= headPress;
            end
        end
    end
endmodule

// File: tb/tb_ps2_lane_decoder.sv
// tb_ps2_lane_decoder: table-driven byte vectors plus hand-written corner
// sequences; expected events go into a scoreboard queue when bytes are driven
// and are compared when the DUT hands an event over (evt_valid && evt_ready).
module tb_ps2_lane_decoder;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PT    = 16;

    typedef struct {
        logic [7:0] data;
        logic [3:0] expHeld;
        logic       expEvt;
        logic [1:0] expLane;
        logic       expPress;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [2:0] expQ [$];

    ps2_lane_decoder_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_lane_decoder #(
        .FIFO_DEPTH(DEPTH),
        .KEY0(8'h1C), .KEY1(8'h1B), .KEY2(8'h23), .KEY3(8'h2B),
        .PREFIX_TIMEOUT(PT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one byte for one cycle; returns #1 after the capturing edge.
    task automatic sendByte(input logic [7:0] b);
        bus.rx_done_tick = 1'b1;
        bus.rx_data      = b;
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
    endtask

    task automatic expectEvt(input logic [1:0] lane, input logic press);
        expQ.push_back({lane, press});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        bus.evt_ready = 1'b0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    // Accept events until the FIFO empties, bounded by a cycle budget.
    task automatic drain(input string name);
        int n;
        n = 0;
        bus.evt_ready = 1'b1;
        while (bus.evt_valid && n < 50) begin
            idle(1);
            n++;
        end
        bus.evt_ready = 1'b0;
        chk({name, "_drain_done"}, int'(bus.evt_valid), 0);
        chk({name, "_sb_empty"}, expQ.size(), 0);
    endtask

    // Scoreboard monitor: every accepted head must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.evt_valid && bus.evt_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got lane %0d press %0d expected no event at %0t",
                         bus.evt_lane, bus.evt_press, $time);
            end else begin
                logic [2:0] e;
                e = expQ.pop_front();
                checks++;
                if ({bus.evt_lane, bus.evt_press} !== e) begin
                    errors++;
                    $display("FAIL sb_event: got lane %0d press %0d expected lane %0d press %0d at %0t",
                             bus.evt_lane, bus.evt_press, e[2:1], e[0], $time);
                end
            end
        end
    end

    vec_t vecs [25];

    initial begin
        checks = 0;
        errors = 0;
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
        bus.evt_ready    = 1'b0;
        reset            = 1'b1;

        vecs[0]  = '{8'h1C, 4'b0001, 1'b1, 2'd0, 1'b1};
        vecs[1]  = '{8'h1C, 4'b0001, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{8'h1C, 4'b0001, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{8'hF0, 4'b0001, 1'b0, 2'd0, 1'b0};
        vecs[4]  = '{8'h1C, 4'b0000, 1'b1, 2'd0, 1'b0};
        vecs[5]  = '{8'hE0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[6]  = '{8'h1C, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[7]  = '{8'hE0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[8]  = '{8'hF0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[9]  = '{8'h1C, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[10] = '{8'hAA, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{8'h1B, 4'b0010, 1'b1, 2'd1, 1'b1};
        vecs[12] = '{8'h23, 4'b0110, 1'b1, 2'd2, 1'b1};
        vecs[13] = '{8'hF0, 4'b0110, 1'b0, 2'd0, 1'b0};
        vecs[14] = '{8'hF0, 4'b0110, 1'b0, 2'd0, 1'b0};
        vecs[15] = '{8'h1B, 4'b0100, 1'b1, 2'd1, 1'b0};
        vecs[16] = '{8'hF0, 4'b0100, 1'b0, 2'd0, 1'b0};
        vecs[17] = '{8'hE0, 4'b0100, 1'b0, 2'd0, 1'b0};
        vecs[18] = '{8'h23, 4'b0100, 1'b0, 2'd0, 1'b0};
        vecs[19] = '{8'h2B, 4'b1100, 1'b1, 2'd3, 1'b1};
        vecs[20] = '{8'hF0, 4'b1100, 1'b0, 2'd0, 1'b0};
        vecs[21] = '{8'h12, 4'b1100, 1'b0, 2'd0, 1'b0};
        vecs[22] = '{8'h2B, 4'b1100, 1'b0, 2'd0, 1'b0};
        vecs[23] = '{8'hF0, 4'b1100, 1'b0, 2'd0, 1'b0};
        vecs[24] = '{8'h23, 4'b1000, 1'b1, 2'd2, 1'b0};

        idle(3);
        reset = 1'b0;
        chk("rst_valid", int'(bus.evt_valid), 0);
        chk("rst_held", int'(bus.held), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_count", int'(bus.fifo_count), 0);
        chk("rst_lane", int'(bus.evt_lane), 0);
        chk("rst_press", int'(bus.evt_press), 0);

        // Latency: no combinational path, head appears one edge after the tick.
        bus.rx_done_tick = 1'b1;
        bus.rx_data      = 8'h1C;
        @(negedge clk);
        chk("lat_valid_before_edge", int'(bus.evt_valid), 0);
        chk("lat_held_before_edge", int'(bus.held), 0);
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
        expectEvt(2'd0, 1'b1);
        chk("lat_valid", int'(bus.evt_valid), 1);
        chk("lat_lane", int'(bus.evt_lane), 0);
        chk("lat_press", int'(bus.evt_press), 1);
        chk("lat_held", int'(bus.held), 1);
        chk("lat_count", int'(bus.fifo_count), 1);
        idle(2);
        chk("lat_hold_valid", int'(bus.evt_valid), 1);
        bus.evt_ready = 1'b1;
        idle(1);
        bus.evt_ready = 1'b0;
        chk("pop_valid", int'(bus.evt_valid), 0);
        chk("pop_count", int'(bus.fifo_count), 0);
        chk("pop_sb_empty", expQ.size(), 0);

        // Table of byte vectors with the consumer always ready.
        doReset();
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (vecs[i].expEvt) expectEvt(vecs[i].expLane, vecs[i].expPress);
            sendByte(vecs[i].data);
            chk($sformatf("vec%0d_held", i), int'(bus.held), int'(vecs[i].expHeld));
        end
        idle(2);
        drain("table");

        // Overflow: six events into a four-deep FIFO with nobody consuming.
        doReset();
        expectEvt(2'd0, 1'b1); sendByte(8'h1C);
        sendByte(8'hF0);
        expectEvt(2'd0, 1'b0); sendByte(8'h1C);
        expectEvt(2'd1, 1'b1); sendByte(8'h1B);
        sendByte(8'hF0);
        expectEvt(2'd1, 1'b0); sendByte(8'h1B);
        sendByte(8'h23);
        chk("ovf_after_push5", int'(bus.overflow), 1);
        sendByte(8'hF0);
        sendByte(8'h23);
        chk("ovf_count", int'(bus.fifo_count), DEPTH);
        chk("ovf_flag", int'(bus.overflow), 1);
        chk("ovf_held", int'(bus.held), 0);
        chk("ovf_head_lane", int'(bus.evt_lane), 0);
        chk("ovf_head_press", int'(bus.evt_press), 1);
        drain("ovf");
        chk("ovf_sticky", int'(bus.overflow), 1);

        // Timeout boundary: one cycle short still completes the break.
        doReset();
        bus.evt_ready = 1'b1;
        expectEvt(2'd3, 1'b1); sendByte(8'h2B);
        sendByte(8'hF0);
        idle(PT - 1);
        expectEvt(2'd3, 1'b0); sendByte(8'h2B);
        chk("to_short_held", int'(bus.held), 0);
        // Full timeout: the break prefix expires, so 2B is a press.
        sendByte(8'hF0);
        idle(PT);
        expectEvt(2'd3, 1'b1); sendByte(8'h2B);
        chk("to_full_held", int'(bus.held), 8);
        idle(2);
        drain("timeout");

        // Full FIFO with a pop in the same cycle as a new make code.
        doReset();
        expectEvt(2'd0, 1'b1); sendByte(8'h1C);
        expectEvt(2'd1, 1'b1); sendByte(8'h1B);
        expectEvt(2'd3, 1'b1); sendByte(8'h2B);
        sendByte(8'hF0);
        expectEvt(2'd0, 1'b0); sendByte(8'h1C);
        chk("full_count", int'(bus.fifo_count), DEPTH);
        bus.evt_ready = 1'b1;
        expectEvt(2'd2, 1'b1); sendByte(8'h23);
        bus.evt_ready = 1'b0;
        chk("fullpop_count", int'(bus.fifo_count), DEPTH);
        chk("fullpop_overflow", int'(bus.overflow), 0);
        chk("fullpop_held", int'(bus.held), 14);
        chk("fullpop_head_lane", int'(bus.evt_lane), 1);
        drain("fullpop");

        // Reset mid-break clears everything, next byte is a plain press.
        sendByte(8'hF0);
        reset = 1'b1;
        idle(1);
        chk("brkrst_held", int'(bus.held), 0);
        chk("brkrst_valid", int'(bus.evt_valid), 0);
        chk("brkrst_count", int'(bus.fifo_count), 0);
        chk("brkrst_overflow", int'(bus.overflow), 0);
        reset = 1'b0;
        expectEvt(2'd0, 1'b1); sendByte(8'h1C);
        chk("brkrst_press_held", int'(bus.held), 1);
        chk("brkrst_press_valid", int'(bus.evt_valid), 1);
        chk("brkrst_press_flag", int'(bus.evt_press), 1);
        drain("brkrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_lane_decoder.md
Name: ps2_lane_decoder

Overview:
- Sits between ps2_rx and the rhythm-game logic in VGAController.
- Turns the raw PS/2 set-2 byte stream (rx_done_tick / rx_data) into clean per-lane press and release events for the four note lanes (A/S/D/F).
- Parses F0 (break) and E0 (extended) prefixes and suppresses typematic repeats.
- Buffers events in a small FIFO with a valid/ready handshake, so the game FSM can consume them at its own pace without polling a stale scan code.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.
- KEY0, 8'h1C, lane 0 make code (A).
- KEY1, 8'h1B, lane 1 make code (S).
- KEY2, 8'h23, lane 2 make code (D).
- KEY3, 8'h2B, lane 3 make code (F).
- PREFIX_TIMEOUT, 200000, clk cycles a prefix state may wait for its next byte (2 ms at 100 MHz).

Ports:
- clk  in  1  100 MHz system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  one-cycle strobe from ps2_rx; rx_data is valid that cycle.
- rx_data  in  8  received scan-code byte.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_lane  out  2  lane index of the head event.
- evt_press  out  1  1 = press, 0 = release.
- held  out  4  current held state per lane; bit i = lane i.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued events.

Behaviour:
- Reset values: state IDLE; held=0; evt_valid=0; evt_lane=0; evt_press=0; overflow=0; fifo_count=0; timeout counter 0. Reset wins over all other inputs in the same cycle and clears any half-received prefix sequence.
- Bytes are examined only in cycles where rx_done_tick=1. rx_data is ignored in all other cycles.
- Parser states and transitions:
  - IDLE:
    - F0 -> BRK.
    - E0 -> EXT.
    - Lane make code -> press handling; stay IDLE.
    - Any other byte (AA, FA, EE, non-lane keys) is ignored; stay IDLE.
  - BRK:
    - Lane code -> release handling, then IDLE.
    - F0 -> stay BRK.
    - E0 -> EXT.
    - Other bytes -> IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay EXT.
    - Any other byte -> IDLE with no event. Extended keys never map to lanes, even when the low byte equals a KEYn value.
  - EXT_BRK:
    - Any byte other than F0/E0 -> IDLE with no event.
    - F0 -> stay EXT_BRK.
- Prefix timeout:
  - In BRK, EXT or EXT_BRK, the counter increments every cycle without rx_done_tick.
  - On reaching PREFIX_TIMEOUT-1 the parser returns to IDLE and the counter clears.
  - The counter clears on every accepted byte and whenever the parser is in IDLE.
- Press handling for lane i:
  - If held[i]=0: set held[i], push {lane=i, press=1}.
  - If held[i]=1 (typematic repeat): no change, no push.
- Release handling for lane i:
  - If held[i]=1: clear held[i], push {i, 0}.
  - If held[i]=0: no change, no push.
- Latency: with rx_done_tick in cycle N and the FIFO empty, held and evt_valid/evt_lane/evt_press update at edge N+1. There is no combinational path from rx inputs to outputs.
- FIFO:
  - Pop occurs when evt_valid && evt_ready. evt_ready while evt_valid=0 has no effect.
  - Simultaneous push and pop at any count, including full, performs both. Count is unchanged, and the pushed entry is not lost.
  - Push while full without a pop drops the event and sets overflow. held is still updated.
  - overflow clears only on reset.
  - Read/write pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
  - Head outputs hold stable while evt_valid=1 and evt_ready=0.
- At most one event is generated per cycle, since ps2_rx issues at most one byte per tick.

Test Plan:
- Reset, then ticks 1C -> evt_valid=1, lane=0, press=1 one cycle after the tick; held=4'b0001. Then evt_ready=1 for one cycle -> evt_valid=0, fifo_count=0.
- Ticks 1C,1C,1C (typematic), then F0,1C -> exactly two events, {0,1} then {0,0}; held returns to 0.
- Ticks E0,1C, then E0,F0,1C -> no events; held stays 0; parser back in IDLE.
- evt_ready=0; press-release A,S,D (6 events) with FIFO_DEPTH=4 -> fifo_count=4, overflow=1. Head sequence {0,1},{0,0},{1,1},{1,0}. held=4'b0000, since lane 2 press and release both updated held even though dropped.
- Tick F0, wait PREFIX_TIMEOUT cycles, tick 2B -> press event {3,1}, not a release.
- Full FIFO with evt_ready=1 in the same cycle as a new make code 23 -> fifo_count stays 4, overflow stays 0, and {2,1} is at the tail. Then assert reset while in BRK -> all outputs 0, and the next byte 1C yields a press.
